// File: rtl/cache_data_bank.sv
// Cache data bank: byte-writable line storage with a registered whole-line read and a critical-word-first refill FSM.
// Optional macro CACHE_DATA_BANK_BYPASS_EN forwards same-cycle writes into the read response (default: read-first).
module cache_data_bank #(
    parameter int SET_BITS       = 7,
    parameter int WORDS_PER_LINE = 8,
    parameter int WORD_WIDTH     = 32,
    localparam int WB            = $clog2(WORDS_PER_LINE),
    localparam int NB            = WORD_WIDTH / 8,
    localparam int LINE_W        = WORD_WIDTH * WORDS_PER_LINE
) (
    input  logic                  i_clk,
    input  logic                  resetn,
    input  logic                  rd_req,
    input  logic [SET_BITS-1:0]   rd_set,
    input  logic [WB-1:0]         rd_word,
    output logic                  rd_valid,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic [LINE_W-1:0]     rd_line,
    input  logic                  st_req,
    input  logic [SET_BITS-1:0]   st_set,
    input  logic [WB-1:0]         st_word,
    input  logic [NB-1:0]         st_ben,
    input  logic [WORD_WIDTH-1:0] st_data,
    output logic                  st_ready,
    input  logic                  rf_start,
    input  logic [SET_BITS-1:0]   rf_set,
    input  logic [WB-1:0]         rf_word,
    input  logic                  rf_valid,
    input  logic [WORD_WIDTH-1:0] rf_data,
    output logic                  rf_ready,
    output logic                  rf_busy,
    output logic                  rf_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] line_t;

    line_t mem [2**SET_BITS];

    logic [1:0]          state_q, state_d;
    logic [WB-1:0]       cnt_q, cnt_d;
    logic [SET_BITS-1:0] rf_set_q;
    logic [WB-1:0]       rf_base_q;

    logic                rd_valid_q;
    logic [WB-1:0]       rd_word_q;
    line_t               rd_line_q, rd_line_d;

    logic                  beat_acc, st_acc, wr_en;
    logic [SET_BITS-1:0]   wr_set;
    logic [WB-1:0]         wr_word;
    logic [NB-1:0]         wr_ben;
    logic [WORD_WIDTH-1:0] wr_data;

    assign st_ready = (state_q == ST_IDLE) && !rf_start;
    assign rf_ready = (state_q == ST_FILL);
    assign rf_busy  = (state_q == ST_FILL) || (state_q == ST_DONE);
    assign rf_done  = (state_q == ST_DONE);

    // Stores are only accepted in IDLE and beats only in FILL, so one write port suffices.
    assign beat_acc = (state_q == ST_FILL) && rf_valid;
    assign st_acc   = st_req && st_ready;
    assign wr_en    = beat_acc || st_acc;
    assign wr_set   = beat_acc ? rf_set_q : st_set;
    assign wr_word  = beat_acc ? WB'(rf_base_q + cnt_q) : st_word;
    assign wr_ben   = beat_acc ? {NB{1'b1}} : st_ben;
    assign wr_data  = beat_acc ? rf_data : st_data;

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wr_en && wr_ben[b])
                mem[wr_set][wr_word][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
    end

    always_comb begin
        rd_line_d = mem[rd_set];
`ifdef CACHE_DATA_BANK_BYPASS_EN
        if (wr_en && (wr_set == rd_set)) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_ben[b])
                    rd_line_d[wr_word][b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (rf_start) begin
                state_d = ST_FILL;
                cnt_d   = '0;
            end
            ST_FILL: if (rf_valid) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == WB'(WORDS_PER_LINE - 1))
                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rf_set_q   <= '0;
            rf_base_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_word_q  <= '0;
            rd_line_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_req;
            if (state_q == ST_IDLE && rf_start) begin
                rf_set_q  <= rf_set;
                rf_base_q <= rf_word;
            end
            // Offset is captured with the request so later rd_word changes cannot alter rd_data.
            if (rd_req) begin
                rd_line_q <= rd_line_d;
                rd_word_q <= rd_word;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_line_q[rd_word_q];
    assign rd_line  = rd_line_q;

endmodule

// File: tb/tb_cache_data_bank.sv
// Randomized self-checking bench for cache_data_bank against an array-based reference model.
module tb_cache_data_bank;
    localparam int SB = 7, WPL = 8, WW = 32, WB = 3, NB = 4, LW = WW * WPL, NS = 2**SB;

    logic i_clk, resetn;
    logic rd_req; logic [SB-1:0] rd_set; logic [WB-1:0] rd_word;
    logic rd_valid; logic [WW-1:0] rd_data; logic [LW-1:0] rd_line;
    logic st_req; logic [SB-1:0] st_set; logic [WB-1:0] st_word; logic [NB-1:0] st_ben;
    logic [WW-1:0] st_data; logic st_ready;
    logic rf_start; logic [SB-1:0] rf_set; logic [WB-1:0] rf_word;
    logic rf_valid; logic [WW-1:0] rf_data; logic rf_ready, rf_busy, rf_done;

    cache_data_bank #(.SET_BITS(SB), .WORDS_PER_LINE(WPL), .WORD_WIDTH(WW)) dut (
        .i_clk(i_clk), .resetn(resetn),
        .rd_req(rd_req), .rd_set(rd_set), .rd_word(rd_word),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_line(rd_line),
        .st_req(st_req), .st_set(st_set), .st_word(st_word), .st_ben(st_ben),
        .st_data(st_data), .st_ready(st_ready),
        .rf_start(rf_start), .rf_set(rf_set), .rf_word(rf_word),
        .rf_valid(rf_valid), .rf_data(rf_data), .rf_ready(rf_ready),
        .rf_busy(rf_busy), .rf_done(rf_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int vecs = 0, errs = 0;
    logic [WW-1:0] mdl [NS][WPL];
    logic [WW-1:0] last_data;
    logic [LW-1:0] last_line;

    task automatic step();
        @(posedge i_clk); #1;
    endtask

    function automatic logic [WW-1:0] merge(logic [WW-1:0] old_w, logic [WW-1:0] new_w, logic [NB-1:0] ben);
        logic [WW-1:0] r = old_w;
        for (int b = 0; b < NB; b++) if (ben[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [LW-1:0] line_of(int s);
        logic [LW-1:0] l;
        for (int w = 0; w < WPL; w++) l[w*WW +: WW] = mdl[s][w];
        return l;
    endfunction

    task automatic idle_inputs();
        rd_req = 0; rd_set = 0; rd_word = 0;
        st_req = 0; st_set = 0; st_word = 0; st_ben = 0; st_data = 0;
        rf_start = 0; rf_set = 0; rf_word = 0; rf_valid = 0; rf_data = 0;
    endtask

    task automatic test_reset();
        idle_inputs(); resetn = 0; rd_req = 1;
        step(); step();
        rd_req = 0;
        vecs++; if (rd_valid !== 1'b0) begin errs++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
        vecs++; if (rd_data !== '0) begin errs++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        vecs++; if (rd_line !== '0) begin errs++; $display("FAIL reset_rd_line got %h want 0", rd_line); end
        vecs++; if ({rf_ready, rf_busy, rf_done} !== 3'b000) begin errs++; $display("FAIL reset_rf got %b want 000", {rf_ready, rf_busy, rf_done}); end
        vecs++; if (st_ready !== 1'b1) begin errs++; $display("FAIL reset_st_ready got %0b want 1", st_ready); end
        resetn = 1;
        last_data = '0; last_line = '0;
    endtask

    task automatic test_fill_all();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < WPL; w++) begin
                st_req = 1; st_set = SB'(s); st_word = WB'(w); st_ben = '1; st_data = $urandom;
                #1;
                vecs++; if (st_ready !== 1'b1) begin errs++; $display("FAIL fill_st_ready set %0d word %0d got %0b want 1", s, w, st_ready); end
                step();
                mdl[s][w] = st_data;
            end
        end
        st_req = 0;
    endtask

    task automatic test_store_byte_en();
        st_req = 1; st_set = 5; st_word = 3; st_ben = 4'hF; st_data = 32'h11223344;
        step(); mdl[5][3] = merge(mdl[5][3], st_data, st_ben);
        st_ben = 4'b0011; st_data = 32'hAABBCCDD;
        step(); mdl[5][3] = merge(mdl[5][3], st_data, st_ben);
        st_req = 0; rd_req = 1; rd_set = 5; rd_word = 3;
        step();
        rd_req = 0; rd_word = 0;
        vecs++; if (rd_valid !== 1'b1) begin errs++; $display("FAIL be_rd_valid got %0b want 1", rd_valid); end
        vecs++; if (rd_data !== 32'h1122CCDD) begin errs++; $display("FAIL be_rd_data got %h want 1122ccdd", rd_data); end
        vecs++; if (rd_line !== line_of(5)) begin errs++; $display("FAIL be_rd_line got %h want %h", rd_line, line_of(5)); end
        step();
        vecs++; if (rd_valid !== 1'b0 || rd_data !== 32'h1122CCDD) begin errs++; $display("FAIL be_hold got v=%0b d=%h want v=0 d=1122ccdd", rd_valid, rd_data); end
        last_data = 32'h1122CCDD; last_line = line_of(5);
    endtask

    task automatic test_random_rw();
        for (int i = 0; i < 300; i++) begin
            logic rd, st;
            int rs, rw;
            logic [LW-1:0] exp_line;
            rd = 1'($urandom); st = 1'($urandom);
            rs = $urandom_range(0, 15); rw = $urandom_range(0, WPL-1);
            rd_req = rd; rd_set = SB'(rs); rd_word = WB'(rw);
            st_req = st; st_set = SB'($urandom_range(0, 15)); st_word = WB'($urandom);
            st_ben = NB'($urandom); st_data = $urandom;
            exp_line = line_of(rs);
`ifdef CACHE_DATA_BANK_BYPASS_EN
            if (st && int'(st_set) == rs)
                exp_line[int'(st_word)*WW +: WW] = merge(exp_line[int'(st_word)*WW +: WW], st_data, st_ben);
`endif
            if (st) mdl[st_set][st_word] = merge(mdl[st_set][st_word], st_data, st_ben);
            if (rd) begin last_line = exp_line; last_data = exp_line[rw*WW +: WW]; end
            step();
            rd_word = WB'($urandom);
            #1;
            vecs++;
            if (rd_valid !== rd || rd_data !== last_data || rd_line !== last_line) begin
                errs++;
                $display("FAIL rand_rw iter %0d got v=%0b d=%h want v=%0b d=%h (line match %0b)", i, rd_valid, rd_data, rd, last_data, rd_line === last_line);
            end
        end
        idle_inputs();
    endtask

    task automatic test_refill_hold_store();
        logic [WW-1:0] sd;
        sd = $urandom;
        st_req = 1; st_set = 7; st_word = 0; st_ben = 4'hF; st_data = sd;
        rf_start = 1; rf_set = 9; rf_word = 6;
        #1;
        vecs++; if (st_ready !== 1'b0) begin errs++; $display("FAIL rf_start_st_ready got %0b want 0", st_ready); end
        step();
        rf_start = 0;
        for (int k = 0; k < WPL; k++) begin
            if (k == 3) begin
                rf_valid = 0; #1;
                vecs++; if (rf_ready !== 1'b1 || rf_done !== 1'b0) begin errs++; $display("FAIL rf_gap got rdy=%0b done=%0b want 1 0", rf_ready, rf_done); end
                step();
            end
            rf_valid = 1; rf_data = 32'hA0 + k;
            rf_start = (k == 5); rf_set = 3; rf_word = 0;
            #1;
            vecs++;
            if (rf_ready !== 1'b1 || rf_busy !== 1'b1 || rf_done !== 1'b0 || st_ready !== 1'b0) begin
                errs++; $display("FAIL rf_beat %0d got rdy=%0b busy=%0b done=%0b st_rdy=%0b want 1 1 0 0", k, rf_ready, rf_busy, rf_done, st_ready);
            end
            step();
            mdl[9][(6 + k) % WPL] = 32'hA0 + k;
        end
        rf_valid = 0; rf_start = 0;
        #1;
        vecs++; if ({rf_done, rf_busy, rf_ready, st_ready} !== 4'b1100) begin errs++; $display("FAIL rf_done_state got %b want 1100", {rf_done, rf_busy, rf_ready, st_ready}); end
        step();
        vecs++; if ({rf_done, rf_busy, st_ready} !== 3'b001) begin errs++; $display("FAIL rf_back_idle got %b want 001", {rf_done, rf_busy, st_ready}); end
        step();
        mdl[7][0] = sd;
        st_req = 0;
        rd_req = 1; rd_set = 9; rd_word = 6;
        step();
        rd_req = 1; rd_set = 7; rd_word = 0;
        vecs++; if (rd_data !== 32'hA0 || rd_line !== line_of(9)) begin errs++; $display("FAIL rf_line9 got d=%h l=%h want d=a0 l=%h", rd_data, rd_line, line_of(9)); end
        vecs++;
        for (int w = 0; w < WPL; w++) begin
            if (rd_line[w*WW +: WW] !== 32'(32'hA0 + (w + 2) % WPL)) begin
                errs++; $display("FAIL rf_order word %0d got %h want %h", w, rd_line[w*WW +: WW], 32'hA0 + (w + 2) % WPL); break;
            end
        end
        step();
        rd_req = 0;
        vecs++; if (rd_data !== sd) begin errs++; $display("FAIL rf_held_store got %h want %h", rd_data, sd); end
        last_data = sd; last_line = line_of(7);
    endtask

    task automatic test_collision();
        logic [WW-1:0] exp;
        st_req = 1; st_set = 20; st_word = 2; st_ben = 4'hF; st_data = 32'h0;
        step(); mdl[20][2] = 32'h0;
        st_data = 32'h12345678; rd_req = 1; rd_set = 20; rd_word = 2;
`ifdef CACHE_DATA_BANK_BYPASS_EN
        exp = 32'h12345678;
`else
        exp = 32'h0;
`endif
        step();
        idle_inputs();
        mdl[20][2] = 32'h12345678;
        vecs++; if (rd_valid !== 1'b1 || rd_data !== exp) begin errs++; $display("FAIL collision got v=%0b d=%h want v=1 d=%h", rd_valid, rd_data, exp); end
        last_data = exp; last_line = rd_line;
    endtask

    task automatic test_reset_midrefill();
        rf_start = 1; rf_set = 30; rf_word = 0;
        step();
        rf_start = 0;
        for (int k = 0; k < 4; k++) begin
            rf_valid = 1; rf_data = 32'hB0 + k;
            step(); mdl[30][k] = 32'hB0 + k;
        end
        rf_valid = 0; resetn = 0; rd_req = 1; rd_set = 30;
        step();
        resetn = 1; rd_req = 0;
        vecs++; if ({rf_busy, rf_ready, rf_done, rd_valid} !== 4'b0000) begin errs++; $display("FAIL midrst_flags got %b want 0000", {rf_busy, rf_ready, rf_done, rd_valid}); end
        vecs++; if (rd_data !== '0 || rd_line !== '0) begin errs++; $display("FAIL midrst_rd got d=%h want 0", rd_data); end
        rf_start = 1; rf_set = 31; rf_word = 5;
        #1;
        vecs++; if (st_ready !== 1'b0) begin errs++; $display("FAIL midrst_st_ready got %0b want 0", st_ready); end
        step();
        rf_start = 0;
        vecs++; if (rf_busy !== 1'b1 || rf_ready !== 1'b1) begin errs++; $display("FAIL midrst_restart got busy=%0b rdy=%0b want 1 1", rf_busy, rf_ready); end
        for (int k = 0; k < WPL; k++) begin
            rf_valid = 1; rf_data = $urandom;
            step(); mdl[31][(5 + k) % WPL] = rf_data;
        end
        rf_valid = 0;
        step();
        rd_req = 1; rd_set = 30; rd_word = 1;
        step();
        rd_set = 31; rd_word = 4;
        vecs++; if (rd_line !== line_of(30)) begin errs++; $display("FAIL midrst_line30 got %h want %h", rd_line, line_of(30)); end
        vecs++; if (rd_line[4*WW-1:0] !== {32'hB3, 32'hB2, 32'hB1, 32'hB0}) begin errs++; $display("FAIL midrst_beats got %h want b3b2b1b0", rd_line[4*WW-1:0]); end
        step();
        rd_req = 0;
        vecs++; if (rd_line !== line_of(31) || rd_data !== mdl[31][4]) begin errs++; $display("FAIL midrst_line31 got d=%h want %h", rd_data, mdl[31][4]); end
    endtask

    initial begin
        test_reset();
        test_fill_all();
        test_store_byte_en();
        test_random_rw();
        test_refill_hold_store();
        test_collision();
        test_reset_midrefill();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
